// File: rtl/fetch_queue.sv
// fetch_queue: circular fetch-to-decode instruction queue.
// Holds up to DEPTH fetch blocks (PC, CORE_WIDTH instructions, slot mask).
// Decode always sees the head entry. Slots that are masked off, and every
// slot when the queue is empty, read as NOP_INSTR.
module fetch_queue #(
    parameter int          CORE_WIDTH = 2,
    parameter int          DEPTH      = 4,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         valid_f,
    output logic                         ready_f,
    input  logic [31:0]                  pc_addr_f,
    input  logic [CORE_WIDTH*32-1:0]     instr_blk_f,
    input  logic [CORE_WIDTH-1:0]        slot_mask_f,
    output logic                         valid_d,
    input  logic                         ready_d,
    output logic [31:0]                  pc_addr_d,
    output logic [CORE_WIDTH*32-1:0]     instr_blk_d,
    output logic [CORE_WIDTH-1:0]        slot_mask_d,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Entry storage is deliberately left unreset; count/pointers gate its visibility.
    logic [31:0]              pc_mem    [DEPTH];
    logic [CORE_WIDTH*32-1:0] instr_mem [DEPTH];
    logic [CORE_WIDTH-1:0]    mask_mem  [DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          enq, deq, store;

    // ready_f does not look at ready_d, so a full queue never takes a block
    // in the same cycle it frees a slot.
    assign ready_f = (count != CW'(DEPTH));
    assign valid_d = (count != '0);
    assign enq     = valid_f & ready_f & ~flush;
    assign deq     = valid_d & ready_d & ~flush;
    // An all-empty block completes its handshake but is not worth a slot.
    assign store   = enq & (|slot_mask_f);

    // Write the offered block into the tail slot.
    always_ff @(posedge clk) begin
        if (store) begin
            pc_mem[wr_ptr]    <= pc_addr_f;
            instr_mem[wr_ptr] <= instr_blk_f;
            mask_mem[wr_ptr]  <= slot_mask_f;
        end
    end

    // Pointer and occupancy bookkeeping; reset and flush clear identically.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the wrap.
            if (store) wr_ptr <= wr_ptr + 1'b1;
            if (deq)   rd_ptr <= rd_ptr + 1'b1;
            case ({store, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head PC and mask read as zero when nothing is buffered.
    always_comb begin
        pc_addr_d   = '0;
        slot_mask_d = '0;
        if (valid_d) begin
            pc_addr_d   = pc_mem[rd_ptr];
            slot_mask_d = mask_mem[rd_ptr];
        end
    end

    // Per-slot NOP fill. An empty queue has a zero mask, so it is covered here too.
    for (genvar i = 0; i < CORE_WIDTH; i++) begin : g_slot
        assign instr_blk_d[32*i +: 32] = slot_mask_d[i] ? instr_mem[rd_ptr][32*i +: 32]
                                                         : NOP_INSTR;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue (DEPTH=4, CORE_WIDTH=2),
// followed by a randomized phase that is compared against a queue model.
module tb_fetch_queue;

    localparam int          CORE_WIDTH = 2;
    localparam int          DEPTH      = 4;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic                       clk = 1'b0;
    logic                       reset, flush, valid_f, ready_f, valid_d, ready_d;
    logic [31:0]                pc_addr_f, pc_addr_d;
    logic [CORE_WIDTH*32-1:0]   instr_blk_f, instr_blk_d;
    logic [CORE_WIDTH-1:0]      slot_mask_f, slot_mask_d;
    logic [$clog2(DEPTH+1)-1:0] count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0]              pc;
        logic [CORE_WIDTH*32-1:0] instr;
        logic [CORE_WIDTH-1:0]    mask;
    } entry_t;

    entry_t model[$];

    fetch_queue #(.CORE_WIDTH(CORE_WIDTH), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .valid_f(valid_f), .ready_f(ready_f), .pc_addr_f(pc_addr_f),
        .instr_blk_f(instr_blk_f), .slot_mask_f(slot_mask_f),
        .valid_d(valid_d), .ready_d(ready_d), .pc_addr_d(pc_addr_d),
        .instr_blk_d(instr_blk_d), .slot_mask_d(slot_mask_d), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Distinct instruction pattern derived from the PC.
    function automatic logic [63:0] blk(input logic [31:0] pc);
        return {16'hB000, pc[15:0], 16'hA000, pc[15:0]};
    endfunction

    task automatic offer(input logic [31:0] pc, input logic [1:0] m);
        valid_f     = 1'b1;
        pc_addr_f   = pc;
        instr_blk_f = blk(pc);
        slot_mask_f = m;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, 128'(valid_d), 128'(1));
        chk({tag, "_pc"}, 128'(pc_addr_d), 128'(pc));
        chk({tag, "_instr"}, 128'(instr_blk_d), 128'(blk(pc)));
    endtask

    task automatic chk_model(input string tag);
        logic [CORE_WIDTH*32-1:0] e_instr;
        e_instr = {CORE_WIDTH{NOP}};
        chk({tag, "_count"}, 128'(count), 128'(model.size()));
        chk({tag, "_valid"}, 128'(valid_d), 128'(model.size() != 0));
        if (model.size() != 0) begin
            for (int s = 0; s < CORE_WIDTH; s++)
                if (model[0].mask[s]) e_instr[32*s +: 32] = model[0].instr[32*s +: 32];
            chk({tag, "_pc"}, 128'(pc_addr_d), 128'(model[0].pc));
            chk({tag, "_mask"}, 128'(slot_mask_d), 128'(model[0].mask));
        end else begin
            chk({tag, "_pc"}, 128'(pc_addr_d), 128'(0));
            chk({tag, "_mask"}, 128'(slot_mask_d), 128'(0));
        end
        chk({tag, "_instr"}, 128'(instr_blk_d), 128'(e_instr));
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; valid_f = 1'b0; ready_d = 1'b0;
        pc_addr_f = '0; instr_blk_f = '0; slot_mask_f = '0;

        // Reset held for two cycles.
        tick(); tick();
        reset = 1'b0;
        chk("rst_valid", 128'(valid_d), 128'(0));
        chk("rst_ready", 128'(ready_f), 128'(1));
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_instr", 128'(instr_blk_d), 128'({NOP, NOP}));
        chk("rst_pc", 128'(pc_addr_d), 128'(0));
        chk("rst_mask", 128'(slot_mask_d), 128'(0));

        // Fill to DEPTH with decode stalled.
        for (int i = 0; i < 4; i++) begin
            offer(32'h100 + 32'(8*i), 2'b11);
            tick();
        end
        chk("fill_count", 128'(count), 128'(4));
        chk("fill_ready", 128'(ready_f), 128'(0));
        chk_head("fill_head", 32'h100);
        offer(32'h120, 2'b11);
        tick();
        chk("full_hold_count", 128'(count), 128'(4));
        chk_head("full_hold_head", 32'h100);
        // First deq while full: 0x120 must not be taken yet.
        ready_d = 1'b1;
        tick();
        chk("deq1_count", 128'(count), 128'(3));
        chk_head("deq1_head", 32'h108);
        tick();
        chk("enq120_count", 128'(count), 128'(3));
        chk_head("deq2_head", 32'h110);
        valid_f = 1'b0;
        tick();
        chk_head("deq3_head", 32'h118);
        tick();
        chk_head("deq4_head", 32'h120);
        chk("deq4_count", 128'(count), 128'(1));
        tick();
        chk("drained_valid", 128'(valid_d), 128'(0));
        chk("drained_count", 128'(count), 128'(0));

        // Partial mask, then an all-zero mask that is not stored.
        ready_d = 1'b0;
        valid_f = 1'b1; pc_addr_f = 32'h200;
        instr_blk_f = {32'hBBBB0033, 32'hAAAA0033}; slot_mask_f = 2'b01;
        tick();
        chk("mask_count", 128'(count), 128'(1));
        chk("mask_instr", 128'(instr_blk_d), 128'({NOP, 32'hAAAA0033}));
        chk("mask_mask", 128'(slot_mask_d), 128'(2'b01));
        chk("mask_pc", 128'(pc_addr_d), 128'(32'h200));
        pc_addr_f = 32'h208; slot_mask_f = 2'b00;
        tick();
        chk("mask0_count", 128'(count), 128'(1));
        chk("mask0_pc", 128'(pc_addr_d), 128'(32'h200));
        valid_f = 1'b0; ready_d = 1'b1;
        tick();
        chk("mask_drain", 128'(count), 128'(0));

        // Steady stream at count=2 with no bubbles.
        ready_d = 1'b0;
        offer(32'h500, 2'b11); tick();
        offer(32'h504, 2'b11); tick();
        chk("stream_pre", 128'(count), 128'(2));
        ready_d = 1'b1;
        for (int i = 0; i < 20; i++) begin
            offer(32'h508 + 32'(4*i), 2'b11);
            tick();
            chk("stream_count", 128'(count), 128'(2));
            chk_head("stream_head", 32'h504 + 32'(4*i));
        end
        valid_f = 1'b0;
        tick(); tick();
        chk("stream_drain", 128'(count), 128'(0));

        // Flush drops contents and the same-cycle offer.
        ready_d = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(32'h600 + 32'(4*i), 2'b11);
            tick();
        end
        chk("preflush_count", 128'(count), 128'(3));
        flush = 1'b1; ready_d = 1'b1;
        offer(32'h300, 2'b11);
        tick();
        flush = 1'b0;
        chk("flush_count", 128'(count), 128'(0));
        chk("flush_valid", 128'(valid_d), 128'(0));
        chk("flush_pc", 128'(pc_addr_d), 128'(0));
        ready_d = 1'b0;
        offer(32'h400, 2'b11);
        tick();
        chk_head("postflush_head", 32'h400);
        chk("postflush_count", 128'(count), 128'(1));

        // Reset mid-stream with count=2.
        offer(32'h700, 2'b11);
        tick();
        chk("prerst_count", 128'(count), 128'(2));
        valid_f = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_count", 128'(count), 128'(0));
        chk("midrst_valid", 128'(valid_d), 128'(0));
        chk("midrst_instr", 128'(instr_blk_d), 128'({NOP, NOP}));

        // Randomized traffic against a queue model, exercising wrap, flush, zero masks.
        for (int c = 0; c < 300; c++) begin
            entry_t e;
            logic   m_enq, m_deq;
            valid_f     = 1'($urandom_range(0, 3) != 0);
            ready_d     = 1'($urandom_range(0, 2) != 0);
            flush       = 1'($urandom_range(0, 19) == 0);
            pc_addr_f   = $urandom;
            instr_blk_f = {$urandom, $urandom};
            slot_mask_f = 2'($urandom_range(0, 3));
            e = '{pc: pc_addr_f, instr: instr_blk_f, mask: slot_mask_f};
            m_enq = valid_f && (model.size() != DEPTH) && !flush;
            m_deq = (model.size() != 0) && ready_d && !flush;
            chk("rand_ready", 128'(ready_f), 128'(model.size() != DEPTH));
            tick();
            if (flush) model.delete();
            else begin
                if (m_deq) void'(model.pop_front());
                if (m_enq && e.mask != '0) model.push_back(e);
            end
            chk_model("rand");
        end
        flush = 1'b0; valid_f = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
